// File: rtl/rat_pkg.sv
// rat_pkg: shared constants for the RAT flag / interrupt logic.
//   FLG_SRC_ALU / FLG_SRC_SHAD : encodings of the FLG_LD_SEL flag-source select.
//   DEF_PEND_W / DEF_SYNC_STAGES : default widths used by flag_intr_unit.
package rat_pkg;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  localparam int unsigned DEF_PEND_W      = 2;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: synchroniser for an asynchronous level plus rising-edge detector.
//   clk       : system clock
//   RESET     : synchronous active-high reset, clears every stage and the edge register
//   async_in  : asynchronous input level
//   edge_out  : one-cycle pulse when the synchronised level goes 0 -> 1
// SYNC_STAGES must be at least 2.
module int_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RESET,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // Bit 0 is the first (metastability-exposed) stage, MSB is the last.
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/flag_intr_unit.sv
// flag_intr_unit: RAT flag state (C, Z, shadow C/Z, interrupt enable I) and the
// pending-interrupt counter that drives INTV into the control unit.
//   clk, RESET          : clock, synchronous active-high reset
//   INT_IN              : asynchronous interrupt request, rising edge significant
//   C_IN, Z_IN          : ALU flag results
//   C_LD, Z_LD          : load C / Z from the source chosen by FLG_LD_SEL
//   C_SET, C_CLEAR      : force C (C_CLEAR wins over C_SET wins over C_LD)
//   FLG_LD_SEL          : 0 = ALU, 1 = shadow (RETIE)
//   FLG_SHAD_LD         : copy pre-edge C/Z into the shadows
//   I_SET, I_CLR        : SEI / CLI
//   INT_ACK             : control unit entered its interrupt state
//   C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG : registered flag state
//   INTV                : pending request and interrupts enabled
//   PEND_CNT            : pending interrupt count (debug)
module flag_intr_unit
  import rat_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned PEND_W      = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              INT_IN,
  input  logic              C_IN,
  input  logic              Z_IN,
  input  logic              C_LD,
  input  logic              Z_LD,
  input  logic              C_SET,
  input  logic              C_CLEAR,
  input  logic              FLG_LD_SEL,
  input  logic              FLG_SHAD_LD,
  input  logic              I_SET,
  input  logic              I_CLR,
  input  logic              INT_ACK,
  output logic              C_FLAG,
  output logic              Z_FLAG,
  output logic              SHAD_C,
  output logic              SHAD_Z,
  output logic              I_FLAG,
  output logic              INTV,
  output logic [PEND_W-1:0] PEND_CNT
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              shad_c_q, shad_c_d;
  logic              shad_z_q, shad_z_d;
  logic              i_q, i_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              int_edge;
  logic              use_shad;

  int_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_int_sync_edge (
    .clk      (clk),
    .RESET    (RESET),
    .async_in (INT_IN),
    .edge_out (int_edge)
  );

  assign use_shad = (FLG_LD_SEL == FLG_SRC_SHAD);

  always_comb begin
    c_d = c_q;
    if (C_CLEAR) begin
      c_d = 1'b0;
    end else if (C_SET) begin
      c_d = 1'b1;
    end else if (C_LD) begin
      c_d = use_shad ? shad_c_q : C_IN;
    end

    z_d = z_q;
    if (Z_LD) begin
      z_d = use_shad ? shad_z_q : Z_IN;
    end

    // Shadows take the pre-edge flags so a simultaneous restore swaps them.
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    if (FLG_SHAD_LD) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end

    i_d = i_q;
    if (INT_ACK || I_CLR) begin
      i_d = 1'b0;
    end else if (I_SET) begin
      i_d = 1'b1;
    end

    // Edge and ack in the same cycle cancel; excess edges at max are dropped.
    pend_d = pend_q;
    if (int_edge && !INT_ACK) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (INT_ACK && !int_edge) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_q      <= 1'b0;
      pend_q   <= '0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
    end
  end

  assign C_FLAG   = c_q;
  assign Z_FLAG   = z_q;
  assign SHAD_C   = shad_c_q;
  assign SHAD_Z   = shad_z_q;
  assign I_FLAG   = i_q;
  assign PEND_CNT = pend_q;
  assign INTV     = (pend_q != '0) & i_q;

endmodule

// File: tb/tb_flag_intr_unit.sv
// tb_flag_intr_unit: directed bench for flag_intr_unit (SYNC_STAGES=2, PEND_W=2).
module tb_flag_intr_unit;

  logic       clk;
  logic       RESET;
  logic       INT_IN;
  logic       C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLEAR;
  logic       FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK;
  logic       C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INTV;
  logic [1:0] PEND_CNT;

  int checks = 0;
  int errors = 0;

  flag_intr_unit #(
    .SYNC_STAGES (2),
    .PEND_W      (2)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .INT_IN      (INT_IN),
    .C_IN        (C_IN),
    .Z_IN        (Z_IN),
    .C_LD        (C_LD),
    .Z_LD        (Z_LD),
    .C_SET       (C_SET),
    .C_CLEAR     (C_CLEAR),
    .FLG_LD_SEL  (FLG_LD_SEL),
    .FLG_SHAD_LD (FLG_SHAD_LD),
    .I_SET       (I_SET),
    .I_CLR       (I_CLR),
    .INT_ACK     (INT_ACK),
    .C_FLAG      (C_FLAG),
    .Z_FLAG      (Z_FLAG),
    .SHAD_C      (SHAD_C),
    .SHAD_Z      (SHAD_Z),
    .I_FLAG      (I_FLAG),
    .INTV        (INTV),
    .PEND_CNT    (PEND_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input bits: {c_in, z_in, c_ld, z_ld, c_set, c_clr, sel, shad_ld, i_set, i_clr, int_ack}
  // Expected bits: {c, z, shad_c, shad_z, i}
  typedef struct packed {
    logic [10:0] in;
    logic [4:0]  ex;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [10:0] in, input logic [4:0] ex);
    vec_t v;
    v.in = in;
    v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    C_IN = 0; Z_IN = 0; C_LD = 0; Z_LD = 0; C_SET = 0; C_CLEAR = 0;
    FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] ex, input logic [1:0] pend,
                         input logic intv);
    chk({tag, ".C"},    32'(C_FLAG),   32'(ex[4]));
    chk({tag, ".Z"},    32'(Z_FLAG),   32'(ex[3]));
    chk({tag, ".SC"},   32'(SHAD_C),   32'(ex[2]));
    chk({tag, ".SZ"},   32'(SHAD_Z),   32'(ex[1]));
    chk({tag, ".I"},    32'(I_FLAG),   32'(ex[0]));
    chk({tag, ".PEND"}, 32'(PEND_CNT), 32'(pend));
    chk({tag, ".INTV"}, 32'(INTV),     32'(intv));
  endtask

  // One INT_IN pulse long enough to produce exactly one synchronised edge and
  // to let the count settle before returning.
  task automatic int_pulse();
    INT_IN = 1;
    tick(); tick();
    INT_IN = 0;
    tick(); tick(); tick();
  endtask

  initial begin
    //                ci zi cl zl cs cc sl sh is ic ia      c z sc sz i
    vecs[0]  = mk(11'b1_0_1_1_0_0_0_0_0_0_0, 5'b1_0_0_0_0);
    vecs[1]  = mk(11'b1_0_1_0_1_1_0_0_0_0_0, 5'b0_0_0_0_0);  // clear beats set and load
    vecs[2]  = mk(11'b0_0_1_0_1_0_0_0_0_0_0, 5'b1_0_0_0_0);  // set beats load
    vecs[3]  = mk(11'b0_1_0_1_0_0_0_0_0_0_0, 5'b1_1_0_0_0);
    vecs[4]  = mk(11'b0_0_0_0_0_0_0_1_0_0_0, 5'b1_1_1_1_0);  // save to shadow
    vecs[5]  = mk(11'b0_0_1_1_0_0_0_0_0_0_0, 5'b0_0_1_1_0);
    vecs[6]  = mk(11'b0_0_1_1_0_0_1_0_0_0_0, 5'b1_1_1_1_0);  // restore from shadow
    vecs[7]  = mk(11'b0_0_0_0_0_1_0_0_0_0_0, 5'b0_1_1_1_0);
    vecs[8]  = mk(11'b0_0_1_1_0_0_1_1_0_0_0, 5'b1_1_0_1_0);  // swap
    vecs[9]  = mk(11'b1_1_1_0_0_0_1_0_0_0_0, 5'b0_1_0_1_0);  // sel=1 ignores C_IN
    vecs[10] = mk(11'b0_0_0_0_0_0_0_0_1_0_0, 5'b0_1_0_1_1);
    vecs[11] = mk(11'b0_0_0_0_0_0_0_0_0_0_0, 5'b0_1_0_1_1);  // hold
    vecs[12] = mk(11'b0_0_0_0_0_0_0_0_1_1_0, 5'b0_1_0_1_0);  // clr beats set
    vecs[13] = mk(11'b0_0_0_0_0_0_0_0_1_0_0, 5'b0_1_0_1_1);
    vecs[14] = mk(11'b0_0_0_0_0_0_0_0_0_1_0, 5'b0_1_0_1_0);
    vecs[15] = mk(11'b0_0_0_0_0_0_0_0_1_0_0, 5'b0_1_0_1_1);
    vecs[16] = mk(11'b0_0_0_0_0_0_0_0_1_0_1, 5'b0_1_0_1_0);  // ack beats set
    vecs[17] = mk(11'b0_0_0_1_0_0_0_0_0_0_0, 5'b0_0_0_1_0);
    vecs[18] = mk(11'b1_0_1_0_0_0_0_1_0_0_0, 5'b1_0_0_0_0);  // shadow takes pre-edge

    idle_inputs();
    INT_IN = 0;
    RESET  = 0;
    #2;

    // Reset dominates C_SET / I_SET / INT_IN; release with INT_IN high.
    RESET = 1; C_SET = 1; I_SET = 1; INT_IN = 1;
    tick();
    chk_all("rst1", 5'b0, 2'd0, 1'b0);
    tick();
    chk_all("rst2", 5'b0, 2'd0, 1'b0);
    RESET = 0; C_SET = 0; I_SET = 0;
    tick();
    chk("rel1.PEND", 32'(PEND_CNT), 32'd0);
    tick();
    chk("rel2.PEND", 32'(PEND_CNT), 32'd0);
    tick();
    chk("rel3.PEND", 32'(PEND_CNT), 32'd1);
    chk("rel3.INTV", 32'(INTV), 32'd0);
    tick();
    chk("rel4.PEND", 32'(PEND_CNT), 32'd1);
    INT_IN = 0;

    // Clean slate for the table.
    RESET = 1;
    tick();
    RESET = 0;
    tick(); tick(); tick();
    chk_all("clean", 5'b0, 2'd0, 1'b0);

    for (int k = 0; k < NVEC; k++) begin
      {C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLEAR, FLG_LD_SEL, FLG_SHAD_LD,
       I_SET, I_CLR, INT_ACK} = vecs[k].in;
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].ex, 2'd0, 1'b0);
    end
    idle_inputs();

    // Latency: INT_IN rises before edge k, INTV high after edge k+2.
    I_SET = 1;
    tick();
    I_SET = 0;
    INT_IN = 1;
    tick();
    chk("lat_k.INTV", 32'(INTV), 32'd0);
    tick();
    chk("lat_k1.INTV", 32'(INTV), 32'd0);
    tick();
    chk("lat_k2.INTV", 32'(INTV), 32'd1);
    chk("lat_k2.PEND", 32'(PEND_CNT), 32'd1);
    tick(); tick();
    INT_IN = 0;
    tick();
    chk("lat_hold.PEND", 32'(PEND_CNT), 32'd1);
    INT_ACK = 1;
    tick();
    INT_ACK = 0;
    chk("ack.PEND", 32'(PEND_CNT), 32'd0);
    chk("ack.I", 32'(I_FLAG), 32'd0);
    chk("ack.INTV", 32'(INTV), 32'd0);
    tick(); tick();

    // Saturation with I=0, then drain.
    for (int p = 0; p < 4; p++) begin
      int_pulse();
      chk($sformatf("sat%0d.PEND", p), 32'(PEND_CNT), (p < 3) ? 32'(p + 1) : 32'd3);
      chk($sformatf("sat%0d.INTV", p), 32'(INTV), 32'd0);
    end
    for (int a = 0; a < 4; a++) begin
      I_SET = 1;
      tick();
      I_SET = 0;
      chk($sformatf("drain%0d.INTV_on", a), 32'(INTV), (a < 3) ? 32'd1 : 32'd0);
      INT_ACK = 1;
      tick();
      INT_ACK = 0;
      chk($sformatf("drain%0d.PEND", a), 32'(PEND_CNT), (a < 3) ? 32'(2 - a) : 32'd0);
      chk($sformatf("drain%0d.INTV", a), 32'(INTV), 32'd0);
    end

    // Edge coinciding with ack leaves the count unchanged.
    int_pulse();
    chk("coin_pre.PEND", 32'(PEND_CNT), 32'd1);
    I_SET = 1;
    tick();
    I_SET = 0;
    chk("coin_pre.INTV", 32'(INTV), 32'd1);
    INT_IN = 1;
    tick(); tick();
    INT_ACK = 1;
    tick();
    INT_ACK = 0;
    INT_IN = 0;
    chk("coin.PEND", 32'(PEND_CNT), 32'd1);
    chk("coin.I", 32'(I_FLAG), 32'd0);
    tick(); tick(); tick();
    chk("coin_after.PEND", 32'(PEND_CNT), 32'd1);
    I_SET = 1;
    tick();
    chk("iset.I", 32'(I_FLAG), 32'd1);
    I_CLR = 1;
    tick();
    I_SET = 0; I_CLR = 0;
    chk("iboth.I", 32'(I_FLAG), 32'd0);
    chk("iboth.INTV", 32'(INTV), 32'd0);

    // Mid-run reset with a pending request and flags set.
    C_SET = 1; I_SET = 1;
    tick();
    C_SET = 0; I_SET = 0;
    chk("pre_rst.INTV", 32'(INTV), 32'd1);
    RESET = 1;
    tick();
    RESET = 0;
    chk_all("rst_mid", 5'b0, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
